// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-buffered UART.
// Contents: register word addresses, STATUS bit positions, parity mode encodings,
// TX/RX FSM state types and small parity helpers.
package uart_pkg;

  // Register word addresses (adr_i)
  localparam logic [1:0] AdrData   = 2'd0;
  localparam logic [1:0] AdrStatus = 2'd1;
  localparam logic [1:0] AdrCtrl   = 2'd2;
  localparam logic [1:0] AdrIrqEn  = 2'd3;

  // STATUS bit positions
  localparam int unsigned StTxEmpty   = 0;
  localparam int unsigned StTxFull    = 1;
  localparam int unsigned StRxEmpty   = 2;
  localparam int unsigned StRxFull    = 3;
  localparam int unsigned StOverrun   = 4;
  localparam int unsigned StParityErr = 5;
  localparam int unsigned StFrameErr  = 6;
  localparam int unsigned StTxBusy    = 7;

  // CTRL[17:16] parity modes; 2'b11 behaves as none
  localparam logic [1:0] ParNone = 2'b00;
  localparam logic [1:0] ParEven = 2'b01;
  localparam logic [1:0] ParOdd  = 2'b10;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == ParEven) || (mode == ParOdd);
  endfunction

  // Bit that makes the total count of ones even (ParEven) or odd (ParOdd)
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    return (^data) ^ (mode == ParOdd);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with combinational head read.
// Ports: clk/rst (sync, active-high), push/wdata, pop/rdata (head), count, full, empty.
// Push on full is dropped unless a pop happens the same cycle; pop on empty is ignored.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CntFull = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CntFull);
  assign do_pop  = pop && !empty;
  // A pop frees the slot, so a push on full still lands when paired with a pop
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, runtime baud divisor, optional parity,
// one or two stop bits, sticky error flags and a level interrupt.
// Ports: clk_i, rst_i (sync, active-high); bus slave adr_i/sel_i/stb_i/we_i/dat_i,
// dat_o/ack_o (registered, one-cycle ack); irq_o; serial uartTx_o (idles high), uartRx_i.
module uart_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned DIV_RESET  = 868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  adr_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        irq_o,
  output logic        uartTx_o,
  input  logic        uartRx_i
);
  import uart_pkg::*;

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [DIV_WIDTH-1:0] DivMin   = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DivReset = DIV_WIDTH'(DIV_RESET);

  // Bus and register state
  logic                 ack_q, rd_pop_q, irq_q, irq_d;
  logic [31:0]          dat_q, rd_data, status_word, ctrl_word, ctrl_wr;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [1:0]           par_q, par_d;
  logic                 stop2_q, stop2_d;
  logic [2:0]           ien_q, ien_d;
  logic                 ovr_q, ovr_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                 req, wr_acc;
  logic                 unused_ctrl;

  // FIFO interfaces
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty, rx_drop;
  logic [7:0]  tx_rdata, rx_rdata;
  logic [AW:0] tx_count, rx_count;

  // TX FSM state
  tx_state_e            tx_state_q, tx_state_d;
  logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [7:0]           tx_shift_q, tx_shift_d, tx_byte_q, tx_byte_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [1:0]           tx_par_q, tx_par_d;
  logic                 tx_stop2_q, tx_stop2_d, tx_stopn_q, tx_stopn_d;
  logic                 tx_line_q, tx_line_d, tx_tick, tx_load;

  // RX FSM state
  rx_state_e            rx_state_q, rx_state_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
  logic [7:0]           rx_shift_q, rx_shift_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [1:0]           rx_par_q, rx_par_d;
  logic                 rx_pbad_q, rx_pbad_d, rx_tick;
  logic                 rx_meta, rx_sync, rx_prev, rx_fall;
  logic                 rx_set_perr, rx_set_ferr;

  assign dat_o    = dat_q;
  assign ack_o    = ack_q;
  assign irq_o    = irq_q;
  assign uartTx_o = tx_line_q;

  // ---------------------------------------------------------------------------
  // Bus handshake: a request is taken when stb is seen with ack low; all side
  // effects happen on the following (ack) cycle while the master still holds stb.
  assign req     = stb_i & ~ack_q;
  assign wr_acc  = ack_q & stb_i & we_i;
  assign tx_push = wr_acc && (adr_i == AdrData) && sel_i[0];
  // Pop only if the head was valid when read data was captured
  assign rx_pop  = ack_q & rd_pop_q;

  always_comb begin
    status_word                = '0;
    status_word[StTxEmpty]     = tx_empty;
    status_word[StTxFull]      = tx_full;
    status_word[StRxEmpty]     = rx_empty;
    status_word[StRxFull]      = rx_full;
    status_word[StOverrun]     = ovr_q;
    status_word[StParityErr]   = perr_q;
    status_word[StFrameErr]    = ferr_q;
    status_word[StTxBusy]      = (tx_state_q != TxIdle);
    status_word[8 +: AW+1]     = rx_count;
    status_word[23:16]         = 8'(tx_count);
    ctrl_word                  = '0;
    ctrl_word[DIV_WIDTH-1:0]   = div_q;
    ctrl_word[17:16]           = par_q;
    ctrl_word[18]              = stop2_q;
    case (adr_i)
      AdrData:   rd_data = rx_empty ? '0 : {24'b0, rx_rdata};
      AdrStatus: rd_data = status_word;
      AdrCtrl:   rd_data = ctrl_word;
      default:   rd_data = {29'b0, ien_q};
    endcase
  end

  always_comb begin
    ctrl_wr = ctrl_word;
    for (int b = 0; b < 4; b++) begin
      if (sel_i[b]) ctrl_wr[8*b +: 8] = dat_i[8*b +: 8];
    end
    div_d   = div_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    ien_d   = ien_q;
    ovr_d   = ovr_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    if (wr_acc) begin
      case (adr_i)
        AdrStatus: if (sel_i[0]) begin
          if (dat_i[StOverrun])   ovr_d  = 1'b0;
          if (dat_i[StParityErr]) perr_d = 1'b0;
          if (dat_i[StFrameErr])  ferr_d = 1'b0;
        end
        AdrCtrl: begin
          div_d   = (ctrl_wr[DIV_WIDTH-1:0] < DivMin) ? DivMin : ctrl_wr[DIV_WIDTH-1:0];
          par_d   = ctrl_wr[17:16];
          stop2_d = ctrl_wr[18];
        end
        AdrIrqEn: if (sel_i[0]) ien_d = dat_i[2:0];
        default: ;
      endcase
    end
    // A new error in the same cycle as its clear wins
    if (rx_drop)     ovr_d  = 1'b1;
    if (rx_set_perr) perr_d = 1'b1;
    if (rx_set_ferr) ferr_d = 1'b1;
    irq_d = (ien_q[0] & ~rx_empty) | (ien_q[1] & tx_empty) |
            (ien_q[2] & (ovr_q | perr_q | ferr_q));
  end

  assign unused_ctrl = ^ctrl_wr[31:19];

  // ---------------------------------------------------------------------------
  // TX: settings are latched per frame so CTRL writes only affect the next one.
  assign tx_tick = (tx_cnt_q == tx_div_q - 1'b1);
  assign tx_pop  = tx_load;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_state_q == TxIdle || tx_tick) ? '0 : tx_cnt_q + 1'b1;
    tx_shift_d = tx_shift_q;
    tx_byte_d  = tx_byte_q;
    tx_bit_d   = tx_bit_q;
    tx_div_d   = tx_div_q;
    tx_par_d   = tx_par_q;
    tx_stop2_d = tx_stop2_q;
    tx_stopn_d = tx_stopn_q;
    tx_load    = 1'b0;
    unique case (tx_state_q)
      TxIdle:  tx_load = !tx_empty;
      TxStart: if (tx_tick) begin
        tx_state_d = TxData;
        tx_bit_d   = '0;
      end
      TxData: if (tx_tick) begin
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        if (tx_bit_q == 3'd7) begin
          tx_state_d = parity_en(tx_par_q) ? TxParity : TxStop;
          tx_stopn_d = 1'b0;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      TxParity: if (tx_tick) begin
        tx_state_d = TxStop;
        tx_stopn_d = 1'b0;
      end
      TxStop: if (tx_tick) begin
        if (tx_stop2_q && !tx_stopn_q) tx_stopn_d = 1'b1;
        else if (!tx_empty)            tx_load    = 1'b1;  // back-to-back, no idle gap
        else                           tx_state_d = TxIdle;
      end
      default: tx_state_d = TxIdle;
    endcase
    if (tx_load) begin
      tx_state_d = TxStart;
      tx_cnt_d   = '0;
      tx_shift_d = tx_rdata;
      tx_byte_d  = tx_rdata;
      tx_div_d   = div_q;
      tx_par_d   = par_q;
      tx_stop2_d = stop2_q;
    end
    // Line is registered from the next state so it changes exactly with the FSM
    case (tx_state_d)
      TxStart:  tx_line_d = 1'b0;
      TxData:   tx_line_d = tx_shift_d[0];
      TxParity: tx_line_d = parity_bit(tx_byte_d, tx_par_d);
      default:  tx_line_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX: two-flop synchroniser, falling-edge start detect, mid-bit sampling.
  assign rx_fall = rx_prev & ~rx_sync;
  assign rx_half = rx_div_q >> 1;
  assign rx_tick = (rx_cnt_q == rx_div_q - 1'b1);
  assign rx_drop = rx_push & rx_full & ~rx_pop;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 1'b1;
    rx_shift_d  = rx_shift_q;
    rx_bit_d    = rx_bit_q;
    rx_div_d    = rx_div_q;
    rx_par_d    = rx_par_q;
    rx_pbad_d   = rx_pbad_q;
    rx_push     = 1'b0;
    rx_set_perr = 1'b0;
    rx_set_ferr = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_state_d = RxStart;
          rx_div_d   = div_q;
          rx_par_d   = par_q;
          rx_pbad_d  = 1'b0;
        end
      end
      RxStart: if (rx_cnt_q == rx_half - 1'b1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync ? RxIdle : RxData;  // high here is a glitch, not a start
      end
      RxData: if (rx_tick) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = parity_en(rx_par_q) ? RxParity : RxStop;
        else                  rx_bit_d   = rx_bit_q + 1'b1;
      end
      RxParity: if (rx_tick) begin
        rx_cnt_d   = '0;
        rx_pbad_d  = (rx_sync != parity_bit(rx_shift_q, rx_par_q));
        rx_state_d = RxStop;
      end
      RxStop: if (rx_tick) begin
        rx_cnt_d    = '0;
        rx_push     = 1'b1;
        rx_set_ferr = ~rx_sync;
        rx_set_perr = rx_pbad_q;
        rx_state_d  = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      rd_pop_q   <= 1'b0;
      irq_q      <= 1'b0;
      div_q      <= DivReset;
      par_q      <= ParNone;
      stop2_q    <= 1'b0;
      ien_q      <= '0;
      ovr_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_byte_q  <= '0;
      tx_bit_q   <= '0;
      tx_div_q   <= DivReset;
      tx_par_q   <= ParNone;
      tx_stop2_q <= 1'b0;
      tx_stopn_q <= 1'b0;
      tx_line_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_div_q   <= DivReset;
      rx_par_q   <= ParNone;
      rx_pbad_q  <= 1'b0;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
    end else begin
      ack_q      <= req;
      dat_q      <= (req && !we_i) ? rd_data : '0;
      rd_pop_q   <= req && !we_i && (adr_i == AdrData) && !rx_empty;
      irq_q      <= irq_d;
      div_q      <= div_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      ien_q      <= ien_d;
      ovr_q      <= ovr_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_byte_q  <= tx_byte_d;
      tx_bit_q   <= tx_bit_d;
      tx_div_q   <= tx_div_d;
      tx_par_q   <= tx_par_d;
      tx_stop2_q <= tx_stop2_d;
      tx_stopn_q <= tx_stopn_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_div_q   <= rx_div_d;
      rx_par_q   <= rx_par_d;
      rx_pbad_q  <= rx_pbad_d;
      rx_meta    <= uartRx_i;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
    end
  end

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (tx_push),
    .wdata (dat_i[7:0]),
    .pop   (tx_pop),
    .rdata (tx_rdata),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (rx_push),
    .wdata (rx_shift_q),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: bus reads push expected data into a
// scoreboard queue that a monitor drains on every read ack; serial line and
// interrupt timing are checked directly against hand-derived values.
`timescale 1ns/1ps
module tb_uart_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  adr = '0;
  logic [3:0]  sel = '0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] dat_w = '0;
  logic [31:0] dat_r;
  logic        ack, irq, tx;
  logic        rx_drv = 1'b1;
  logic        loopback = 1'b0;
  logic        rx_line;

  assign rx_line = loopback ? tx : rx_drv;

  uart_fifo dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .adr_i    (adr),
    .sel_i    (sel),
    .stb_i    (stb),
    .we_i     (we),
    .dat_i    (dat_w),
    .dat_o    (dat_r),
    .ack_o    (ack),
    .irq_o    (irq),
    .uartTx_o (tx),
    .uartRx_i (rx_line)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every read ack consumes one expected value
  always @(negedge clk) begin
    if (!rst && ack && !we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got 0x%08h, expected no read", dat_r);
      end else begin
        check(name_q.pop_front(), dat_r, exp_q.pop_front());
      end
    end
  end

  task automatic bus(input logic w, input logic [1:0] a, input logic [3:0] s,
                     input logic [31:0] d);
    int k;
    @(posedge clk); #1;
    stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!ack && k < 8);
    if (!ack) begin
      n_checks++;
      n_fail++;
      $display("FAIL bus_ack: got no ack, expected ack within 8 cycles");
    end
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(1'b1, a, 4'hF, d);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    bus(1'b0, a, 4'hF, 32'h0);
  endtask

  task automatic drive_bit(input logic v, input int div);
    rx_drv = v;
    repeat (div) @(posedge clk);
    #1;
  endtask

  // par: 0 none, 1 even, 2 odd
  task automatic send_frame(input logic [7:0] b, input int div, input int par,
                            input logic flip_par, input logic stop);
    logic p;
    @(posedge clk); #1;
    drive_bit(1'b0, div);
    for (int i = 0; i < 8; i++) drive_bit(b[i], div);
    if (par != 0) begin
      p = (^b) ^ (par == 2) ^ flip_par;
      drive_bit(p, div);
    end
    drive_bit(stop, div);
    drive_bit(1'b1, 2 * div);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5;
    int         k;
    a5 = 8'hA5;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_tx_idle", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_dat_o", dat_r, 32'd0);
    rd(2'd1, 32'h0000_0005, "rst_status");
    rd(2'd2, 32'd868, "rst_ctrl");
    rd(2'd0, 32'h0, "rx_empty_read");

    // Byte-lane masked CTRL write and divisor clamp
    bus(1'b1, 2'd2, 4'b0001, 32'h1234_56FF);
    rd(2'd2, 32'h0000_03FF, "ctrl_lane0_only");
    wr(2'd2, 32'd1);
    rd(2'd2, 32'd2, "ctrl_div_clamp");

    // TX waveform of 0xA5 at div 4
    wr(2'd2, 32'd4);
    wr(2'd0, 32'hA5);
    k = 0;
    while (tx && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("tx_start_seen", {31'b0, tx}, 32'd0);
    repeat (2) @(posedge clk);
    #1 check("tx_start_mid", {31'b0, tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(posedge clk);
      #1 check($sformatf("tx_bit%0d", i), {31'b0, tx}, {31'b0, a5[i]});
    end
    repeat (4) @(posedge clk);
    #1 check("tx_stop", {31'b0, tx}, 32'd1);
    repeat (4) @(posedge clk);
    rd(2'd1, 32'h0000_0005, "tx_done_status");

    // Loopback with even parity and two stop bits
    wr(2'd2, 32'h0005_0004);
    loopback = 1'b1;
    wr(2'd0, 32'h03);
    wr(2'd0, 32'h07);
    wr(2'd0, 32'h55);
    repeat (250) @(posedge clk);
    rd(2'd1, 32'h0000_0301, "loop_status_cnt3");
    rd(2'd0, 32'h03, "loop_byte0");
    rd(2'd0, 32'h07, "loop_byte1");
    rd(2'd0, 32'h55, "loop_byte2");
    rd(2'd1, 32'h0000_0005, "loop_no_parity_err");
    loopback = 1'b0;

    // RX overrun: 9 frames, no reads
    wr(2'd2, 32'd4);
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 4, 0, 1'b0, 1'b1);
    rd(2'd1, 32'h0000_0819, "ovr_status");
    bus(1'b1, 2'd1, 4'b0001, 32'h10);
    rd(2'd1, 32'h0000_0809, "ovr_cleared");
    for (int i = 0; i < 8; i++) rd(2'd0, 32'h10 + i, $sformatf("ovr_byte%0d", i));
    rd(2'd1, 32'h0000_0005, "ovr_drained");

    // Frame error with interrupt timing: flag set 41 edges after frame start
    wr(2'd3, 32'd4);
    check("irq_idle", {31'b0, irq}, 32'd0);
    fork
      send_frame(8'h3C, 4, 0, 1'b0, 1'b0);
      begin
        repeat (42) @(posedge clk);
        #1 check("irq_same_cycle_as_flag", {31'b0, irq}, 32'd0);
        @(posedge clk);
        #1 check("irq_one_after_flag", {31'b0, irq}, 32'd1);
      end
    join
    rd(2'd1, 32'h0000_0141, "ferr_status");
    bus(1'b1, 2'd1, 4'b0001, 32'h40);

    // Parity error: odd parity, wrong parity bit
    wr(2'd2, 32'h0002_0004);
    send_frame(8'h5A, 4, 2, 1'b1, 1'b1);
    rd(2'd1, 32'h0000_0221, "perr_status");
    check("irq_perr", {31'b0, irq}, 32'd1);
    rd(2'd0, 32'h3C, "ferr_byte_kept");
    rd(2'd0, 32'h5A, "perr_byte_kept");
    bus(1'b1, 2'd1, 4'b0001, 32'h70);
    rd(2'd1, 32'h0000_0005, "errs_cleared");
    check("irq_cleared", {31'b0, irq}, 32'd0);

    // TX FIFO fill with a stalled transmitter, then reset mid-frame
    wr(2'd2, 32'h0000_FFFF);
    for (int i = 0; i < 9; i++) wr(2'd0, 32'h80 + i);
    rd(2'd1, 32'h0008_0086, "tx_full_9");
    wr(2'd0, 32'h99);
    rd(2'd1, 32'h0008_0086, "tx_full_drop");
    check("tx_in_start", {31'b0, tx}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check("rst_mid_tx_high", {31'b0, tx}, 32'd1);
    rst = 1'b0;
    rd(2'd1, 32'h0000_0005, "rst_mid_status");
    rd(2'd2, 32'd868, "rst_mid_ctrl");

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
